// File: rtl/i2c_target_regs.sv
// I2C target endpoint: 7-bit address match, auto-incrementing byte register
// bank writable/readable over I2C, plus a registered sideband read port.
// SDA is driven open-drain through sda_oe; SCL is observed only (no stretching).
module i2c_target_regs #(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        system_clock,
    input  logic                        reset,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        sda_oe,
    input  logic [$clog2(NUM_REGS)-1:0] reg_rd_addr,
    output logic [7:0]                  reg_rd_data,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic                        start_det,
    output logic                        stop_det,
    output logic                        bus_busy
);
    localparam int unsigned PW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
    logic                   scl_prev_reg, sda_prev_reg;
    logic                   scl_s, sda_s;
    logic                   start_cond, stop_cond, scl_rise, scl_fall;
    logic [7:0]             rx_byte;

    state_t        state_reg, state_next;
    logic [3:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          rw_reg, rw_next;
    logic [PW-1:0] ptr_reg, ptr_next;
    logic          sda_oe_reg, sda_oe_next;
    logic          busy_reg, busy_next;
    logic          start_pulse_reg, start_pulse_next;
    logic          stop_pulse_reg, stop_pulse_next;
    logic          wr_strobe_reg;
    logic [PW-1:0] wr_index_reg;
    logic          wr_en;
    logic [PW-1:0] wr_idx;
    logic [7:0]    wr_byte;

    logic [7:0]          bank_reg [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [7:0]          prefetch_reg;
    logic [7:0]          rd_data_reg;

    // Bring the bus wires into the clock domain and keep the previous sample for edge detection
    always_ff @(posedge system_clock) begin
        if (reset) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_i};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_i};
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
        end
    end

    assign scl_s      = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s      = sda_sync_reg[SYNC_STAGES-1];
    assign start_cond = scl_prev_reg & scl_s & sda_prev_reg & ~sda_s;
    assign stop_cond  = scl_prev_reg & scl_s & ~sda_prev_reg & sda_s;
    assign scl_rise   = ~scl_prev_reg & scl_s;
    assign scl_fall   = scl_prev_reg & ~scl_s;
    assign rx_byte    = {shift_reg[6:0], sda_s};

    // Protocol state and datapath registers
    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            rw_reg          <= 1'b0;
            ptr_reg         <= '0;
            sda_oe_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            start_pulse_reg <= 1'b0;
            stop_pulse_reg  <= 1'b0;
            wr_strobe_reg   <= 1'b0;
            wr_index_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            rw_reg          <= rw_next;
            ptr_reg         <= ptr_next;
            sda_oe_reg      <= sda_oe_next;
            busy_reg        <= busy_next;
            start_pulse_reg <= start_pulse_next;
            stop_pulse_reg  <= stop_pulse_next;
            wr_strobe_reg   <= wr_en;
            wr_index_reg    <= wr_idx;
        end
    end

    // Next-state logic; START/STOP override any bit-level action in the same cycle.
    // In the ACK states sda_oe_reg doubles as the phase flag: the first SCL fall
    // starts driving the ACK, the second fall ends the slot.
    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        rw_next          = rw_reg;
        ptr_next         = ptr_reg;
        sda_oe_next      = sda_oe_reg;
        busy_next        = busy_reg;
        start_pulse_next = 1'b0;
        stop_pulse_next  = 1'b0;
        wr_en            = 1'b0;
        wr_idx           = ptr_reg;
        wr_byte          = rx_byte;

        if (start_cond) begin
            state_next       = ST_ADDR;
            bit_cnt_next     = '0;
            sda_oe_next      = 1'b0;
            start_pulse_next = 1'b1;
            busy_next        = 1'b1;
        end else if (stop_cond) begin
            state_next      = ST_IDLE;
            sda_oe_next     = 1'b0;
            stop_pulse_next = 1'b1;
            busy_next       = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next = '0;
                            if (state_reg == ST_ADDR) begin
                                if (rx_byte[7:1] == TARGET_ADDR) begin
                                    state_next = ST_ADDR_ACK;
                                    rw_next    = rx_byte[0];
                                end else begin
                                    state_next = ST_IGNORE;
                                end
                            end else if (state_reg == ST_PTR) begin
                                ptr_next   = rx_byte[PW-1:0];
                                state_next = ST_PTR_ACK;
                            end else begin
                                wr_en      = 1'b1;
                                ptr_next   = ptr_reg + PW'(1);
                                state_next = ST_WR_ACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_reg) begin
                            sda_oe_next = 1'b1;
                        end else begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = '0;
                            if (state_reg != ST_ADDR_ACK) begin
                                state_next = ST_WR_DATA;
                            end else if (rw_reg) begin
                                // first read bit goes out on the same fall that ends the ACK
                                state_next  = ST_RD_DATA;
                                shift_next  = prefetch_reg;
                                sda_oe_next = ~prefetch_reg[7];
                            end else begin
                                state_next = ST_PTR;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == 4'd0) begin
                            shift_next  = prefetch_reg;
                            sda_oe_next = ~prefetch_reg[7];
                        end else if (bit_cnt_reg == 4'd8) begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = '0;
                            state_next   = ST_RD_ACK;
                        end else begin
                            shift_next  = {shift_reg[6:0], 1'b0};
                            sda_oe_next = ~shift_reg[6];
                        end
                    end else if (scl_rise && bit_cnt_reg != 4'd8) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        ptr_next     = ptr_reg + PW'(1);
                        bit_cnt_next = '0;
                        state_next   = sda_s ? ST_IGNORE : ST_RD_DATA;
                    end
                end
                default: begin
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    // Per-entry write decode
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_hit
            assign wr_hit[gi] = wr_en && (wr_idx == PW'(gi));
        end
    endgenerate

    // Register bank with registered read ports (I2C prefetch and sideband)
    always_ff @(posedge system_clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_reg[i] <= '0;
            end
            prefetch_reg <= '0;
            rd_data_reg  <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) begin
                    bank_reg[i] <= wr_byte;
                end
            end
            prefetch_reg <= bank_reg[ptr_reg];
            rd_data_reg  <= bank_reg[reg_rd_addr];
        end
    end

    assign sda_oe      = sda_oe_reg;
    assign reg_rd_data = rd_data_reg;
    assign wr_strobe   = wr_strobe_reg;
    assign wr_index    = wr_index_reg;
    assign start_det   = start_pulse_reg;
    assign stop_det    = stop_pulse_reg;
    assign bus_busy    = busy_reg;
endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave) endpoint attached to the bus `sda`/`scl` wires.
- Samples the bus and detects START, repeated START and STOP.
- Matches a 7-bit address and serves an auto-incrementing byte register bank. The bank is written by the controller and readable both over I2C and through a local sideband port.
- Drives SDA open-drain only. SCL is input-only: no clock stretching.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target ACKs.
- NUM_REGS, 16, register bank depth. Must be a power of 2, range 2..256.
- SYNC_STAGES, 2, synchronizer flops on `scl_i`/`sda_i`. Minimum 2.

Ports:
- system_clock  input  1  sole clock. Rising edge.
- reset  input  1  synchronous, active-high reset.
- scl_i  input  1  resolved SCL wire. High-Z reads as 1.
- sda_i  input  1  resolved SDA wire. High-Z reads as 1.
- sda_oe  output  1  1 = pull SDA low. 0 = release (Z).
- reg_rd_addr  input  $clog2(NUM_REGS)  sideband read index.
- reg_rd_data  output  8  registered bank[reg_rd_addr]. 1-cycle latency.
- wr_strobe  output  1  1-cycle pulse when a bank byte is written over I2C.
- wr_index  output  $clog2(NUM_REGS)  index written. Valid with `wr_strobe`.
- start_det  output  1  1-cycle pulse on START or repeated START.
- stop_det  output  1  1-cycle pulse on STOP.
- bus_busy  output  1  1 from START until STOP.

Behaviour:
- **Reset:**
  - `sda_oe` = 0; all pulses = 0; `bus_busy` = 0; `reg_rd_data` = 0.
  - Bank all 0x00; pointer = 0; state = IDLE.
  - Synchronizer flops and previous-value flops reset to 1.
  - Reset mid-transfer releases SDA on the reset clock edge and aborts the transfer. No further bank writes occur.
- **Sampling:**
  - `scl_s`/`sda_s` are SYNC_STAGES-flop synchronized copies.
  - Edges are found by comparing against the previous synced value.
  - START = `sda_s` falls while `scl_s` is 1 and stays 1.
  - STOP = `sda_s` rises while `scl_s` is 1.
  - Data bits are sampled on the `scl_s` rising edge.
  - `sda_oe` updates on the cycle after the `scl_s` falling edge. Bus-pin-to-`sda_oe` latency = SYNC_STAGES+1 cycles.
  - Bus SCL high and low phases must each be ≥ SYNC_STAGES+4 cycles.
- **START/STOP precedence:**
  - START (any state, including mid-byte) → ADDR. Bit counter cleared, `sda_oe` = 0, `start_det` pulse, `bus_busy` = 1.
  - STOP (any state) → IDLE. `sda_oe` = 0, `stop_det` pulse, `bus_busy` = 0.
  - START/STOP edges take precedence over any data-bit action in the same cycle.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first.
    - If [7:1] == TARGET_ADDR → ADDR_ACK, and latch the R/W bit.
    - Else → IGNORE, with SDA released for the ACK slot (NACK).
  - ADDR_ACK: `sda_oe` = 1 from the falling edge after bit 8 until the next falling edge.
    - W → PTR.
    - R → RD_DATA, loading shift = bank[ptr].
  - PTR: 8 bits. ptr = byte[$clog2(NUM_REGS)-1:0] (upper bits ignored). Then PTR_ACK (ACK).
  - PTR_ACK → WR_DATA.
  - WR_DATA: 8 bits. On the 8th rising edge:
    - bank[ptr] ← byte; `wr_strobe` pulse; `wr_index` = ptr.
    - ptr ← ptr+1, wrapping NUM_REGS-1 → 0.
    - Then WR_ACK (always ACK) → WR_DATA.
  - RD_DATA: drive `sda_oe` = ~shift[7] after each falling edge; shift left on each falling edge after a bit. After 8 bits, release SDA → RD_ACK.
  - RD_ACK: sample SDA on the rising edge.
    - 0 (ACK): ptr ← ptr+1 (wrap); load bank[ptr+1]; → RD_DATA.
    - 1 (NACK): → IGNORE.
    - ptr also increments after a NACKed byte.
  - IGNORE: `sda_oe` = 0 until START or STOP.
- **Pointer:**
  - Persists across transactions. Cleared only by reset.
  - Repeated START after PTR gives a standard random read from the new ptr.
- **Sideband read:** a write and a sideband read to the same index in the same cycle return the old data.

Test Plan:
- Reset, then check idle outputs → `sda_oe` = 0, `bus_busy` = 0, sideband reads of all indices return 0x00.
- Write: START, 0xA0, 0x03, 0x11, 0x22, STOP.
  - ACK on all 4 bytes.
  - `wr_strobe` ×2 with `wr_index` 3 then 4.
  - bank[3] = 0x11, bank[4] = 0x22.
  - `start_det`/`stop_det` pulse once each.
- Random read: START, 0xA0, 0x03, Sr, 0xA1, read 2 bytes (ACK, then NACK), STOP.
  - SDA returns 0x11, 0x22.
  - SDA released after the NACK.
  - ptr = 5.
- Wrap: write ptr 0x0F, then data 0xAA, 0xBB.
  - bank[15] = 0xAA, bank[0] = 0xBB.
  - ptr = 1.
  - Ptr byte 0x2F also selects index 15.
- Address 0xA2 (mismatch) followed by data bytes → no ACK, no `wr_strobe`, bank unchanged.
- Reset asserted during the 4th bit of a read byte → `sda_oe` = 0 on that edge, state IDLE, next START+0xA1 reads bank[0].
